// File: rtl/neuron.sv
`default_nettype none
// ============================================================================
// Module   : neuron
// Purpose  : Three-dendrite integrate-and-fire neuron with refractory period.
//            Optional leaky integration is compiled in with `define LEAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neuron #(
  parameter int W_WIDTH   = 4,
  parameter int POT_WIDTH = 8,
  parameter int THRESHOLD = 64,
  parameter int REFRACT   = 4,
  parameter int LEAK      = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 de1,
  input  logic                 de2,
  input  logic                 de3,
  input  logic [W_WIDTH-1:0]   w1,
  input  logic [W_WIDTH-1:0]   w2,
  input  logic [W_WIDTH-1:0]   w3,
  output logic [POT_WIDTH-1:0] potential,
  output logic                 out_pulse,
  output logic                 en,
  output logic [7:0]           spike_count
);

  localparam int c_EW = POT_WIDTH + 2;
  localparam logic [c_EW-1:0] c_THRESH  = c_EW'(THRESHOLD);
  localparam logic [7:0]      c_REFRACT = 8'(REFRACT);

  if ((THRESHOLD < 1) || (THRESHOLD > (2**POT_WIDTH) - 1) ||
      (REFRACT < 1) || (REFRACT > 255) || (LEAK < 0)) begin : g_param_check
    $error("neuron: illegal parameter value");
  end

  typedef enum logic [0:0] {
    ST_INTEG   = 1'b0,
    ST_REFRACT = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [W_WIDTH-1:0]     r_r1, r_r2, r_r3;
  logic [POT_WIDTH-1:0]   r_pot, w_pot_nxt;
  logic                   r_pulse, w_pulse_nxt;
  logic [7:0]             r_cnt, w_cnt_nxt;
  logic [7:0]             r_spk, w_spk_nxt;
  logic [c_EW-1:0]        w_sum, w_raw, w_nxt;

  assign w_sum = c_EW'(r_r1) + c_EW'(r_r2) + c_EW'(r_r3);
  assign w_raw = c_EW'(r_pot) + w_sum;

`ifdef LEAK_EN
  localparam logic [c_EW-1:0] c_LEAK = c_EW'(LEAK);
  // Saturate at zero rather than wrapping when the leak exceeds the charge.
  assign w_nxt = (w_raw >= c_LEAK) ? (w_raw - c_LEAK) : '0;
`else
  assign w_nxt = w_raw;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pot_nxt   = r_pot;
    w_pulse_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_spk_nxt   = r_spk;
    case (r_state)
      ST_INTEG: begin
        if (w_nxt >= c_THRESH) begin
          w_state_nxt = ST_REFRACT;
          w_pot_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = c_REFRACT;
          w_spk_nxt   = r_spk + 8'd1;
        end else begin
          // Below threshold implies the value fits in POT_WIDTH bits.
          w_pot_nxt = w_nxt[POT_WIDTH-1:0];
        end
      end
      ST_REFRACT: begin
        w_pot_nxt = '0;
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = ST_INTEG;
        end
      end
      default: begin
        w_state_nxt = ST_INTEG;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_state <= ST_INTEG;
      r_pot   <= '0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
      r_spk   <= '0;
    end else begin
      r_r1    <= de1 ? w1 : '0;
      r_r2    <= de2 ? w2 : '0;
      r_r3    <= de3 ? w3 : '0;
      r_state <= w_state_nxt;
      r_pot   <= w_pot_nxt;
      r_pulse <= w_pulse_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spk   <= w_spk_nxt;
    end
  end

  assign potential   = r_pot;
  assign out_pulse   = r_pulse;
  assign en          = (r_state == ST_INTEG);
  assign spike_count = r_spk;

endmodule
`default_nettype wire

// File: tb/tb_neuron.sv
`default_nettype none
// Testbench for neuron: randomized and directed stimulus checked against a
// cycle-level behavioural model of the integrate-and-fire rules.
module tb_neuron;

  localparam int W_WIDTH   = 4;
  localparam int POT_WIDTH = 8;
  localparam int THRESHOLD = 64;
  localparam int REFRACT   = 4;
  localparam int LEAK      = 1;
`ifdef LEAK_EN
  localparam int M_LEAK    = LEAK;
`else
  localparam int M_LEAK    = 0;
`endif

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic                 de1, de2, de3;
  logic [W_WIDTH-1:0]   w1, w2, w3;
  logic [POT_WIDTH-1:0] potential;
  logic                 out_pulse;
  logic                 en;
  logic [7:0]           spike_count;

  neuron #(
    .W_WIDTH(W_WIDTH), .POT_WIDTH(POT_WIDTH), .THRESHOLD(THRESHOLD),
    .REFRACT(REFRACT), .LEAK(LEAK)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .de1(de1), .de2(de2), .de3(de3),
    .w1(w1), .w2(w2), .w3(w3),
    .potential(potential), .out_pulse(out_pulse),
    .en(en), .spike_count(spike_count)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: charge waiting in the weight pipeline, potential, remaining
  // refractory cycles, spike tally.
  int m_pend;
  int m_pot;
  int m_refr;
  int m_spk;
  bit m_pulse;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit d1, input bit d2, input bit d3,
                        input int a, input int b, input int c);
    de1 = d1; de2 = d2; de3 = d3;
    w1 = W_WIDTH'(a); w2 = W_WIDTH'(b); w3 = W_WIDTH'(c);
  endtask

  task automatic model_edge();
    int gated;
    int charge;
    gated = (de1 ? int'(w1) : 0) + (de2 ? int'(w2) : 0) + (de3 ? int'(w3) : 0);
    if (Rst) begin
      m_pend = 0; m_pot = 0; m_refr = 0; m_spk = 0; m_pulse = 0;
      return;
    end
    charge  = m_pend;
    m_pend  = gated;
    m_pulse = 0;
    if (m_refr > 0) begin
      m_refr--;
      m_pot = 0;
    end else begin
      m_pot = m_pot + charge - M_LEAK;
      if (m_pot < 0) m_pot = 0;
      if (m_pot >= THRESHOLD) begin
        m_pot   = 0;
        m_pulse = 1;
        m_refr  = REFRACT;
        m_spk   = (m_spk + 1) % 256;
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    chk("potential", int'(potential), m_pot);
    chk("out_pulse", int'(out_pulse), int'(m_pulse));
    chk("en", int'(en), (m_refr == 0) ? 1 : 0);
    chk("spike_count", int'(spike_count), m_spk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    run(2);
    Rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int budget;
    Rst = 1'b1;
    set_in(1, 1, 1, 8, 4, 15);
    m_pend = 0; m_pot = 0; m_refr = 0; m_spk = 0; m_pulse = 0;

    // Reset with nonzero weights, then 8+4+15 = 27 per cycle.
    run(2);
    chk("rst_potential", int'(potential), 0);
    chk("rst_en", int'(en), 1);
    chk("rst_spikes", int'(spike_count), 0);
    Rst = 1'b0;
    cycle();
    chk("first_sum_latency", int'(potential), 0);
    cycle();
    chk("pot_step1", int'(potential), 27 - M_LEAK);
    cycle();
    chk("pot_step2", int'(potential), 54 - 2 * M_LEAK);
    cycle();
    chk("fire_pulse", int'(out_pulse), 1);
    chk("fire_pot", int'(potential), 0);
    cycle();
    chk("refract_en", int'(en), 0);
    chk("single_pulse", int'(out_pulse), 0);
    run(20);

    // 7+3+7 = 17: fires on the 4th integrating edge either way.
    do_reset();
    set_in(1, 1, 1, 7, 3, 7);
    run(4);
    cycle();
    chk("fire_717", int'(out_pulse), 1);

    // Stop feeding after potential reaches 34 (32 with leak).
    do_reset();
    run(2);
    set_in(1, 1, 1, 0, 0, 0);
    cycle();
    chk("partial_pot", int'(potential), 34 - 2 * M_LEAK);
    run(40);
    chk("idle_pot", int'(potential), (M_LEAK != 0) ? 0 : 34);

    // Enable gating: de3 low, sum 12; then wiggle enables in refractory.
    do_reset();
    set_in(1, 1, 0, 8, 4, 15);
    run(14);
    for (int i = 0; i < 12; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 15, 15, 15);
      cycle();
    end

    // Reset in the middle of refractory.
    do_reset();
    set_in(1, 1, 1, 15, 15, 15);
    run(4);
    chk("mid_refr_en_low", int'(en), 0);
    Rst = 1'b1;
    cycle();
    chk("mid_refr_rst_en", int'(en), 1);
    chk("mid_refr_rst_pot", int'(potential), 0);
    Rst = 1'b0;
    run(8);

    // Spike counter wraps after 256 spikes.
    do_reset();
    pulses = 0;
    budget = 4000;
    while (pulses < 256 && budget > 0) begin
      cycle();
      if (out_pulse) pulses++;
      budget--;
    end
    chk("wrap_budget", (pulses == 256) ? 1 : 0, 1);
    chk("wrap_count", int'(spike_count), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      Rst = ($urandom_range(63) == 0);
      set_in(1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(15)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/neuron.md
Name: neuron

Overview:
- Three-input integrate-and-fire artificial neuron for small spiking datapaths.
- Each dendrite has an enable and a 4-bit synaptic weight. Gated weights are registered, summed and integrated into a membrane potential every clock.
- When the potential reaches THRESHOLD the neuron emits a one-cycle spike, clears its potential and goes refractory (inhibited) for a fixed number of cycles.
- Used as a leaf cell; downstream logic consumes out_pulse and spike_count.

Parameters:
- W_WIDTH, 4: width of each synaptic weight.
- POT_WIDTH, 8: width of the membrane potential register.
- THRESHOLD, 64: firing threshold. Legal range is 1..2^POT_WIDTH-1.
- REFRACT, 4: refractory length in cycles. Legal range is 1..255.
- LEAK, 1: amount subtracted per active cycle when the leak feature is compiled in.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  reset, synchronous and active-high.
- de1, de2, de3  input  1 each  dendrite enables.
- w1, w2, w3  input  W_WIDTH each  synaptic weights, unsigned.
- potential  output  POT_WIDTH  current membrane potential (registered).
- out_pulse  output  1  spike; high for exactly one cycle per firing.
- en  output  1  1 = integrating, 0 = refractory/inhibited.
- spike_count  output  8  number of spikes since reset; wraps 255 -> 0.

Behaviour:
- Reset (Rst=1 at a rising edge) forces all of the following on that edge, overriding all other activity including a mid-refractory state:
  - r1..r3 = 0, potential = 0, out_pulse = 0
  - en = 1, refractory counter = 0, spike_count = 0
- Stage 1, every cycle including refractory cycles: r_i <= de_i ? w_i : 0.
- Stage 2 sum: sum = r1 + r2 + r3, zero-extended. Maximum is 3*(2^W_WIDTH-1) = 45 with the default width.
- Latency: a weight or enable change is visible in r_i one cycle later and affects potential two cycles later.
- Integrating, en=1:
  - nxt = potential + sum, minus LEAK if LEAK_EN is defined.
  - nxt is computed in POT_WIDTH+2 bits. It floors at 0 and never wraps.
  - If nxt >= THRESHOLD:
    - out_pulse <= 1, potential <= 0, en <= 0
    - counter <= REFRACT, spike_count <= spike_count + 1
  - Otherwise: potential <= nxt and out_pulse <= 0.
- Refractory, en=0:
  - out_pulse <= 0; potential is held at 0; sums are discarded.
  - The counter decrements each cycle. On the cycle it goes from 1 to 0, en <= 1.
  - en is therefore low for exactly REFRACT cycles, and integration resumes on the following edge.
- out_pulse can never be high in two consecutive cycles.
- The minimum spike-to-spike spacing is REFRACT+1 cycles.
- All-zero weights or all enables low: no spike.
  - Without leak, potential holds its value.
  - With leak, potential decays by LEAK per cycle down to 0.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro LEAK_EN.
- Defined: LEAK is subtracted on every integrating cycle, floored at 0, giving a leaky integrate-and-fire neuron.
- Undefined: pure integrator; the LEAK parameter is unused and no subtractor is synthesized.

Test Plan:
- Reset: hold Rst=1 for 2 cycles with nonzero weights -> potential=0, out_pulse=0, en=1, spike_count=0; after release the first sum reaches potential on the 2nd edge.
- Weights w1=8, w2=4, w3=15, all de=1, no leak -> potential 27, 54, then out_pulse=1 with potential=0 on the 3rd integrate edge.
  - en then stays 0 for 4 cycles and spikes repeat every 7 cycles.
  - With LEAK_EN the potential sequence is 26, 52, then fire.
- Weights 7, 3, 7 -> no leak: potential 17, 34, 51, then fire on the 4th edge. With LEAK_EN: 16, 32, 48, then 64 >= 64 fires on the 4th edge.
- All weights 0 after a partial integration (potential=34) -> no leak: potential stays 34 with no pulse. With LEAK_EN: decays 33, 32, ... to 0 and holds at 0.
- Enable gating: de3=0 with weights 8, 4, 15 -> sum 12. Potential 12, 24, 36, 48, 60, then fires at 72. Toggling de mid-refractory has no effect on potential.
- Reset asserted in the middle of refractory -> en=1 and counter=0 on the next edge; integration restarts from 0. spike_count wraps from 255 to 0 after 256 spikes.
